mips_mc_control: RTL and testbench

//  Multicycle MIPS main controller FSM. Sits directly upstream of the datapath and drives all of its control inputs.

---
 rtl/mips_mc_control.sv | 168 ++++++++++++++++
 tb/tb_mips_mc_control.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main controller: Moore FSM driving the datapath control inputs,
// with a stall hold, a sticky illegal-opcode halt and a retired-instruction counter.
module mips_mc_control #(
  parameter int CNT_W         = 32,
  parameter bit HALT_ON_ILLEG = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       OP,
  input  logic             stall,
  output logic             IorD,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             Branch,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic [3:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JEX    = 4'd11,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] retired_reg;
  logic             retire;
  logic             ir_write_raw, pc_write_raw, mem_write_raw, reg_write_raw, branch_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      retired_reg <= '0;
    end else if (!stall) begin
      state_reg <= state_next;
      if (retire)
        retired_reg <= retired_reg + CNT_ONE;
    end
  end

  // Next state; unused encodings fall through to FETCH.
  always_comb begin
    state_next = S_FETCH;
    retire     = 1'b0;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (OP)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXEC;
          OP_BEQ:       state_next = S_BEQ;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JEX;
          default:      state_next = HALT_ON_ILLEG ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: state_next = (OP == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = S_MEMWB;
      S_EXEC:   state_next = S_ALUWB;
      S_ADDIEX: state_next = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BEQ, S_ADDIWB, S_JEX: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    IorD          = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    PCSrc         = 2'b00;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    ir_write_raw  = 1'b0;
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    branch_raw    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        ALUSrcB      = 2'b01;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD:  IorD = 1'b1;
      S_MEMWB: begin
        reg_write_raw = 1'b1;
        MemtoReg      = 1'b1;
      end
      S_MEMWR: begin
        IorD          = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        RegDst        = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        PCSrc      = 2'b01;
        branch_raw = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: reg_write_raw = 1'b1;
      S_JEX: begin
        PCSrc        = 2'b10;
        pc_write_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Stall masks only the state-changing enables, and does so in the same cycle.
  assign IRWrite  = ir_write_raw  & ~stall;
  assign PCWrite  = pc_write_raw  & ~stall;
  assign MemWrite = mem_write_raw & ~stall;
  assign RegWrite = reg_write_raw & ~stall;
  assign Branch   = branch_raw    & ~stall;

  assign state   = state_reg;
  assign halted  = (state_reg == S_HALT);
  assign retired = retired_reg;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: a CNT_W=4 halting instance plus a
// non-halting twin sharing the same inputs.
module tb_mips_mc_control;
  logic       clk = 1'b0;
  logic       reset, stall;
  logic [5:0] OP;

  logic       IorD, ALUSrcA, IRWrite, PCWrite, MemWrite, RegWrite, Branch, RegDst, MemtoReg, halted;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] state, retired;

  logic       IorD2, ALUSrcA2, IRWrite2, PCWrite2, MemWrite2, RegWrite2, Branch2, RegDst2, MemtoReg2, halted2;
  logic [1:0] ALUSrcB2, ALUOp2, PCSrc2;
  logic [3:0] state2, retired2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mips_mc_control #(.CNT_W(4), .HALT_ON_ILLEG(1'b1)) u_dut (
    .clk(clk), .reset(reset), .OP(OP), .stall(stall),
    .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .Branch(Branch), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .state(state), .halted(halted), .retired(retired)
  );

  mips_mc_control #(.CNT_W(4), .HALT_ON_ILLEG(1'b0)) u_nohalt (
    .clk(clk), .reset(reset), .OP(OP), .stall(stall),
    .IorD(IorD2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ALUOp(ALUOp2), .PCSrc(PCSrc2),
    .IRWrite(IRWrite2), .PCWrite(PCWrite2), .MemWrite(MemWrite2), .RegWrite(RegWrite2),
    .Branch(Branch2), .RegDst(RegDst2), .MemtoReg(MemtoReg2),
    .state(state2), .halted(halted2), .retired(retired2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] wens();
    return {IRWrite, PCWrite, MemWrite, RegWrite, Branch};
  endfunction

  initial begin
    reset = 1'b1; stall = 1'b0; OP = 6'b000000;
    step(); step();
    chk("rst_state", state, 0);
    chk("rst_retired", retired, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fetch_wens", wens(), 5'b11000);
    chk("rst_fetch_srcb", ALUSrcB, 2'b01);

    // lw: 0,1,2,3,4,0
    reset = 1'b0; OP = 6'b100011;
    step(); chk("lw_decode", state, 1); chk("lw_dec_srcb", ALUSrcB, 2'b11); chk("lw_dec_wens", wens(), 0);
    step(); chk("lw_memadr", state, 2); chk("lw_adr_srca", ALUSrcA, 1); chk("lw_adr_srcb", ALUSrcB, 2'b10);
    step(); chk("lw_memrd", state, 3); chk("lw_rd_iord", IorD, 1);
    step(); chk("lw_memwb", state, 4); chk("lw_wb_regwr", RegWrite, 1); chk("lw_wb_m2r", MemtoReg, 1);
    chk("lw_wb_retired", retired, 0);
    step(); chk("lw_fetch", state, 0); chk("lw_retired", retired, 1);

    // beq
    OP = 6'b000100;
    step(); chk("beq_decode", state, 1);
    step(); chk("beq_state", state, 8); chk("beq_branch", Branch, 1); chk("beq_pcsrc", PCSrc, 2'b01);
    chk("beq_aluop", ALUOp, 2'b01); chk("beq_pcwrite", PCWrite, 0);
    step(); chk("beq_fetch", state, 0); chk("beq_retired", retired, 2);

    // sw with a 3-cycle stall in MEMWR
    OP = 6'b101011;
    step(); step(); chk("sw_memadr", state, 2);
    step(); chk("sw_memwr", state, 5); chk("sw_memwrite", MemWrite, 1); chk("sw_iord", IorD, 1);
    stall = 1'b1; #1;
    chk("stall_same_cycle", MemWrite, 0); chk("stall_iord_kept", IorD, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_state", state, 5); chk("stall_memwrite", MemWrite, 0); chk("stall_retired", retired, 2);
    end
    stall = 1'b0; #1;
    chk("unstall_memwrite", MemWrite, 1); chk("unstall_state", state, 5);
    step(); chk("sw_fetch", state, 0); chk("sw_memwrite_off", MemWrite, 0); chk("sw_retired", retired, 3);

    // R-type
    OP = 6'b000000;
    step();
    step(); chk("r_exec", state, 6); chk("r_aluop", ALUOp, 2'b10); chk("r_srca", ALUSrcA, 1);
    step(); chk("r_aluwb", state, 7); chk("r_regwr", RegWrite, 1); chk("r_regdst", RegDst, 1);
    step(); chk("r_fetch", state, 0); chk("r_retired", retired, 4);

    // addi
    OP = 6'b001000;
    step();
    step(); chk("addi_ex", state, 9); chk("addi_srcb", ALUSrcB, 2'b10);
    step(); chk("addi_wb", state, 10); chk("addi_regwr", RegWrite, 1); chk("addi_regdst", RegDst, 0);
    step(); chk("addi_fetch", state, 0); chk("addi_retired", retired, 5);

    // reset in EXEC aborts the instruction
    OP = 6'b000000;
    step();
    step(); chk("abort_exec", state, 6); chk("abort_regwr_exec", RegWrite, 0); chk("abort_cnt_pre", retired, 5);
    reset = 1'b1;
    step(); chk("abort_fetch", state, 0); chk("abort_regwr", RegWrite, 0); chk("abort_retired", retired, 0);
    reset = 1'b0;

    // illegal opcode
    OP = 6'b111111;
    step(); chk("ill_decode", state, 1);
    step(); chk("ill_halt", state, 15); chk("ill_halted", halted, 1);
    chk("nohalt_fetch", state2, 0); chk("nohalt_halted", halted2, 0);
    for (int i = 0; i < 22; i++) begin
      step();
      chk("halt_state", state, 15); chk("halt_wens", wens(), 0);
    end
    chk("nohalt_retired", retired2, 0);
    reset = 1'b1;
    step(); chk("halt_rst_state", state, 0); chk("halt_rst_halted", halted, 0); chk("halt_rst_retired", retired, 0);

    // j x16: counter wraps from 15 to 0
    reset = 1'b0; OP = 6'b000010;
    for (int n = 1; n <= 16; n++) begin
      step();
      step();
      if (n == 16) begin
        chk("j_state", state, 11); chk("j_pcwrite", PCWrite, 1); chk("j_pcsrc", PCSrc, 2'b10);
      end
      step();
    end
    chk("j_fetch", state, 0); chk("wrap_retired", retired, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
